// File: rtl/occupancy_counter.sv
// occupancy_counter: edge-detects sensor entry/exit levels and keeps a saturating parking occupancy count.
// Optional BCD_VAGAS_EN adds registered BCD tens/units of the free-space count.
module occupancy_counter #(
  parameter int CAPACIDADE = 7,
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         contar,
  input  logic         up_down,
  output logic [W-1:0] ocupadas,
  output logic [W-1:0] livres,
  output logic         lotado,
  output logic         vazio,
  output logic         erro
`ifdef BCD_VAGAS_EN
  ,
  output logic [3:0]   livres_dez,
  output logic [3:0]   livres_uni
`endif
);
  localparam logic [W-1:0] CAP = W'(CAPACIDADE);
  logic         contar_q, up_down_q;
  logic [W-1:0] ocup_q, ocup_d, livres_q, livres_d;
  logic         lotado_q, vazio_q, erro_q, erro_d;
  logic         ent, sai, inc, dec;
  assign ent = contar & ~contar_q;
  assign sai = up_down & ~up_down_q;
  assign inc = ent & ~sai & (ocup_q != CAP);
  assign dec = sai & ~ent & (ocup_q != '0);
  always_comb begin
    erro_d   = (ent & ~sai & (ocup_q == CAP)) | (sai & ~ent & (ocup_q == '0));
    ocup_d   = inc ? ocup_q + 1'b1 : dec ? ocup_q - 1'b1 : ocup_q;
    livres_d = inc ? livres_q - 1'b1 : dec ? livres_q + 1'b1 : livres_q;
  end
  // Edge registers load live inputs during reset so a held level never fires on release.
  always_ff @(posedge CLK) begin
    contar_q  <= contar;
    up_down_q <= up_down;
    if (reset) begin
      ocup_q   <= '0;
      livres_q <= CAP;
      lotado_q <= 1'b0;
      vazio_q  <= 1'b1;
      erro_q   <= 1'b0;
    end else begin
      ocup_q   <= ocup_d;
      livres_q <= livres_d;
      lotado_q <= ocup_d == CAP;
      vazio_q  <= ocup_d == '0;
      erro_q   <= erro_d;
    end
  end
  assign ocupadas = ocup_q;
  assign livres   = livres_q;
  assign lotado   = lotado_q;
  assign vazio    = vazio_q;
  assign erro     = erro_q;
`ifdef BCD_VAGAS_EN
  logic [3:0] dez_q, uni_q;
  always_ff @(posedge CLK) begin
    if (reset) begin
      dez_q <= 4'(CAPACIDADE / 10);
      uni_q <= 4'(CAPACIDADE % 10);
    end else begin
      dez_q <= 4'(32'(livres_d) / 32'd10);
      uni_q <= 4'(32'(livres_d) % 32'd10);
    end
  end
  assign livres_dez = dez_q;
  assign livres_uni = uni_q;
`endif
endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
- Sits directly downstream of the parking-gate sensor FSM and consumes its `contar` (car entered) and `up_down` (car left) outputs.
- Turns those level outputs into single entry/exit events and keeps a saturating count of occupied spaces.
- Produces free-space count, full/empty flags and an error pulse for the display and barrier logic.
- One clock domain, fully registered outputs.

Parameters:
- CAPACIDADE, 7: number of parking spaces; legal range 1 .. 2^W-1.
- W, 3: width of the occupancy and free-space counters.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- contar  input  1  entry indication from the sensor FSM; a level that may stay high for many cycles.
- up_down  input  1  exit indication from the sensor FSM; a level, typically one cycle long.
- ocupadas  output  W  occupied spaces, registered.
- livres  output  W  free spaces, registered; always equals CAPACIDADE - ocupadas.
- lotado  output  1  high while ocupadas == CAPACIDADE.
- vazio  output  1  high while ocupadas == 0.
- erro  output  1  one-cycle pulse when a rejected event occurs (overflow or underflow).

Behaviour:
- Reset is synchronous and active-high; only reset is used for initialisation, no initial blocks.
- While reset is sampled high at posedge CLK:
  - ocupadas=0, livres=CAPACIDADE, vazio=1, lotado=0, erro=0.
  - Edge registers load the current contar/up_down values, so a level held high across reset release produces no event.
- Edge detection: registers contar_q and up_down_q hold the input values from the previous posedge.
  - ent = contar & ~contar_q
  - sai = up_down & ~up_down_q
  - A level held for N cycles gives exactly one event.
  - An input must return to 0 for at least one sampled cycle before it can generate another event.
- Update: at the posedge where ent/sai are evaluated true, the counter and all outputs update in that same edge. Outputs are therefore visible one cycle after the first high sample of the input.
- Event rules:
  - ent only, ocupadas < CAPACIDADE: ocupadas+1, livres-1.
  - ent only, ocupadas == CAPACIDADE: count unchanged, erro=1 for one cycle.
  - sai only, ocupadas > 0: ocupadas-1, livres+1.
  - sai only, ocupadas == 0: count unchanged, erro=1 for one cycle.
  - ent and sai in the same cycle: count unchanged, erro=0, including when full or empty.
  - No event: all state holds, erro=0.
- No wrap-around, ever: the counter saturates at 0 and at CAPACIDADE.
- Flags are registered and computed from the next-state count, so they are never out of step with ocupadas.
- livres is a separate register updated consistently; invariant ocupadas + livres == CAPACIDADE holds every cycle.
- Reset mid-operation: takes effect on the next posedge regardless of pending events; the event in that cycle is discarded.

Optional Feature:
- Macro: BCD_VAGAS_EN.
- Defined:
  - Adds outputs livres_dez [3:0] and livres_uni [3:0], the BCD tens and units of livres.
  - Registered and updated on the same edge as livres.
  - Reset values: BCD of CAPACIDADE.
  - CAPACIDADE must be ≤ 99.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold contar=1 for 5 cycles -> exactly one increment: ocupadas=1, livres=6, vazio=0, erro never asserted.
- 7 separate one-cycle contar pulses, then an 8th -> ocupadas=7 and lotado=1 after the 7th; 8th gives erro=1 for one cycle with ocupadas still 7.
- From empty after reset, one up_down pulse -> erro=1 for one cycle, ocupadas=0, vazio=1.
- With ocupadas=3, raise contar and up_down on the same cycle -> ocupadas stays 3, erro=0. With ocupadas=7, same stimulus -> stays 7, erro=0.
- Hold contar=1 across reset deassertion, then drop it -> no event, ocupadas=0. Apply reset when ocupadas=5 with a contar edge in the same cycle -> ocupadas=0 next cycle.
- With BCD_VAGAS_EN defined, CAPACIDADE=12, W=4, 3 entries -> livres=9, livres_dez=0, livres_uni=9. Reset -> livres_dez=1, livres_uni=2.
